// File: rtl/proc_mem_pkg.sv
// Shared state encoding and default sizing for the processor/host memory arbiter.
package proc_mem_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_TIMEOUT = 65535;
  localparam int RUN_CNT_W   = 32;
endpackage

// File: rtl/sp_ram.sv
// Single-port RAM with registered, read-before-write output.
module sp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Array has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (en) rdata <= mem[addr];
  end
endmodule

// File: rtl/proc_mem_arbiter.sv
// Hands a single-port memory between a host and a processor; tracks run length and timeout.
module proc_mem_arbiter
  import proc_mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 host_en,
  input  logic                 host_we,
  input  logic [ADDR_W-1:0]    host_addr,
  input  logic [DATA_W-1:0]    host_wdata,
  output logic [DATA_W-1:0]    host_rdata,
  output logic                 host_rvalid,
  output logic                 host_err,
  input  logic                 cpu_en,
  input  logic                 cpu_we,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [DATA_W-1:0]    cpu_wdata,
  output logic [DATA_W-1:0]    cpu_rdata,
  input  logic                 cpu_end,
  output logic                 cpu_run,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [RUN_CNT_W-1:0] run_cycles
);
  state_e state_q, state_d;

  logic              run;
  logic              timeout_hit;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              host_rd, cpu_rd;
  logic [DATA_W-1:0] host_hold, cpu_hold;

  assign run     = (state_q == ST_RUN);
  assign cpu_run = run;
  assign busy    = run;
  assign done    = (state_q == ST_FINISH);

  // True during the RUN cycle that would bring the count to TIMEOUT.
  assign timeout_hit = ({1'b0, run_cycles} + 33'd1) >= 33'(TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_RUN;
      ST_RUN:    if (cpu_end || timeout_hit) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Single memory port: owner selected purely by FSM state.
  assign ram_en    = run ? cpu_en    : host_en;
  assign ram_we    = run ? cpu_we    : host_we;
  assign ram_addr  = run ? cpu_addr  : host_addr;
  assign ram_wdata = run ? cpu_wdata : host_wdata;

  sp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cycles <= '0;
      timeout    <= 1'b0;
      host_err   <= 1'b0;
      host_rd    <= 1'b0;
      cpu_rd     <= 1'b0;
      host_hold  <= '0;
      cpu_hold   <= '0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        run_cycles <= '0;
        timeout    <= 1'b0;
      end else if (run) begin
        if (run_cycles != '1) run_cycles <= run_cycles + 32'd1;
        // Coincident cpu_end wins: treated as a normal completion.
        if (state_d == ST_FINISH) timeout <= timeout_hit && !cpu_end;
      end
      host_err <= run && host_en;
      host_rd  <= !run && host_en && !host_we;
      cpu_rd   <= run && cpu_en;
      if (host_rd) host_hold <= ram_rdata;
      if (cpu_rd)  cpu_hold  <= ram_rdata;
    end
  end

  assign host_rvalid = host_rd;
  assign host_rdata  = host_rd ? ram_rdata : host_hold;
  assign cpu_rdata   = cpu_rd  ? ram_rdata : cpu_hold;
endmodule
